// File: rtl/prbs_ber_checker_pkg.sv
// Shared constants and types for the PRBS9 BER checker.
// Seed matches the upstream PRBS9 generator.
package prbs_ber_checker_pkg;

  localparam int NB_DELAY_DEF   = 9;
  localparam int WINDOW_DEF     = 511;
  localparam int NB_WIN_DEF     = 9;
  localparam int LOS_THRESH_DEF = 64;
  localparam int NB_COUNT_DEF   = 64;

  localparam logic [8:0] PRBS9_SEED = 9'h0AB;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/prbs_ber_checker_window.sv
// Fixed-length error window shared by the delay search and the lock monitor.
// window_done flags the last sample; final_cnt includes that sample.
module ber_window_counter
  import prbs_ber_checker_pkg::*;
#(
  parameter int NB_WIN = NB_WIN_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              clear,
  input  logic              sample,
  input  logic              mismatch,
  output logic              window_done,
  output logic [NB_WIN-1:0] final_cnt
);

  localparam int WIN_END = WINDOW - 1;
  localparam logic [NB_WIN-1:0] WIN_LAST = WIN_END[NB_WIN-1:0];

  logic [NB_WIN-1:0] win_cnt;
  logic [NB_WIN-1:0] err_win;

  assign window_done = sample && (win_cnt == WIN_LAST);
  assign final_cnt   = err_win + NB_WIN'(mismatch);

  always_ff @(posedge clock) begin
    if (i_reset || clear) begin
      win_cnt <= '0;
      err_win <= '0;
    end else if (window_done) begin
      win_cnt <= '0;
      err_win <= '0;
    end else if (sample) begin
      win_cnt <= win_cnt + NB_WIN'(1);
      err_win <= final_cnt;
    end
  end

endmodule

// File: rtl/prbs_ber_checker.sv
// Delay search, lock and BER accumulation on PRBS9 reference vs received bits.
// Delay line tap(d) holds the reference from d samples ago.
module prbs_ber_checker
  import prbs_ber_checker_pkg::*;
#(
  parameter int NB_DELAY   = NB_DELAY_DEF,
  parameter int WINDOW     = WINDOW_DEF,
  parameter int NB_WIN     = NB_WIN_DEF,
  parameter int LOS_THRESH = LOS_THRESH_DEF,
  parameter int NB_COUNT   = NB_COUNT_DEF
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic                i_ref_bit,
  input  logic                i_rx_bit,
  input  logic                i_resync,
  output logic                o_locked,
  output logic [NB_DELAY-1:0] o_delay,
  output logic [NB_WIN:0]     o_min_err,
  output logic [NB_COUNT-1:0] o_err_count,
  output logic [NB_COUNT-1:0] o_bit_count
);

  localparam int DEPTH = 2 ** NB_DELAY;
  localparam logic [NB_DELAY-1:0] D_MAX = '1;
  localparam logic [NB_WIN:0] LOS_T = LOS_THRESH[NB_WIN:0];

  state_t state_q;
  state_t state_d;

  logic [DEPTH-2:0]    dline;
  logic [DEPTH-1:0]    taps;
  logic [NB_DELAY-1:0] cur_d;
  logic [NB_DELAY-1:0] best_d;
  logic [NB_DELAY-1:0] best_nx;
  logic [NB_DELAY-1:0] lock_d;
  logic [NB_WIN-1:0]   final_cnt;
  logic [NB_WIN:0]     final_ext;

  logic sample;
  logic mismatch;
  logic win_done;
  logic better;
  logic early;
  logic sweep_end;
  logic enter_lock;
  logic los_hit;

  assign sample    = i_enable && i_valid && !i_resync;
  assign taps      = {dline, i_ref_bit};
  assign mismatch  = i_rx_bit ^ taps[cur_d];

  assign final_ext = {1'b0, final_cnt};
  assign better    = final_ext < o_min_err;
  assign best_nx   = better ? cur_d : best_d;
  assign early     = final_cnt == '0;
  assign sweep_end = cur_d == D_MAX;
  assign lock_d    = early ? cur_d : best_nx;

  assign enter_lock = win_done && (state_q == SEARCH)
                      && (early || sweep_end);
  assign los_hit    = win_done && (state_q == LOCKED)
                      && (final_ext > LOS_T);

  ber_window_counter #(
    .NB_WIN (NB_WIN),
    .WINDOW (WINDOW)
  ) u_win (
    .clock       (clock),
    .i_reset     (i_reset),
    .clear       (i_resync),
    .sample      (sample),
    .mismatch    (mismatch),
    .window_done (win_done),
    .final_cnt   (final_cnt)
  );

  always_ff @(posedge clock) begin
    if (i_reset) state_q <= SEARCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      i_resync:   state_d = SEARCH;
      enter_lock: state_d = LOCKED;
      los_hit:    state_d = SEARCH;
      default:    state_d = state_q;
    endcase
  end

  always_comb begin
    o_locked = (state_q == LOCKED);
  end

  always_ff @(posedge clock) begin
    if (i_reset) dline <= '0;
    else if (sample) dline <= {dline[DEPTH-3:0], i_ref_bit};
  end

  // In LOCKED cur_d holds the locked delay so one tap mux serves both modes.
  always_ff @(posedge clock) begin
    if (i_reset || i_resync || los_hit) begin
      cur_d     <= '0;
      best_d    <= '0;
      o_min_err <= '1;
    end else if (win_done && state_q == SEARCH) begin
      if (better) begin
        o_min_err <= final_ext;
        best_d    <= cur_d;
      end
      if (early || sweep_end) cur_d <= lock_d;
      else                    cur_d <= cur_d + NB_DELAY'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) o_delay <= '0;
    else if (!i_resync && enter_lock) o_delay <= lock_d;
  end

  always_ff @(posedge clock) begin
    if (i_reset || i_resync) begin
      o_err_count <= '0;
      o_bit_count <= '0;
    end else if (sample && state_q == LOCKED) begin
      if (!(&o_bit_count))
        o_bit_count <= o_bit_count + NB_COUNT'(1);
      if (!(&o_err_count))
        o_err_count <= o_err_count + NB_COUNT'(mismatch);
    end
  end

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Directed bench for prbs_ber_checker: lock search, BER counts, LOS, resync,
// gated sampling and reset, on a small configuration (32 delays, 31-bit window).
module tb_prbs_ber_checker;
  import prbs_ber_checker_pkg::*;

  localparam int NB_DELAY = 5;
  localparam int WINDOW   = 31;
  localparam int NB_WIN   = 5;
  localparam int LOS_TH   = 4;
  localparam int NB_COUNT = 64;

  logic clock = 1'b0;
  logic i_reset = 1'b1;
  logic i_enable = 1'b0;
  logic i_valid = 1'b0;
  logic i_ref_bit = 1'b0;
  logic i_rx_bit = 1'b0;
  logic i_resync = 1'b0;
  logic                o_locked;
  logic [NB_DELAY-1:0] o_delay;
  logic [NB_WIN:0]     o_min_err;
  logic [NB_COUNT-1:0] o_err_count;
  logic [NB_COUNT-1:0] o_bit_count;

  int errors = 0;
  int checks = 0;
  logic [8:0]  lfsr = PRBS9_SEED;
  logic [63:0] hist = '0;
  int since_lock = 0;
  longint exp_bits = 0;
  longint exp_err = 0;

  always #5 clock = ~clock;

  prbs_ber_checker #(
    .NB_DELAY   (NB_DELAY),
    .WINDOW     (WINDOW),
    .NB_WIN     (NB_WIN),
    .LOS_THRESH (LOS_TH),
    .NB_COUNT   (NB_COUNT)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_ref_bit   (i_ref_bit),
    .i_rx_bit    (i_rx_bit),
    .i_resync    (i_resync),
    .o_locked    (o_locked),
    .o_delay     (o_delay),
    .o_min_err   (o_min_err),
    .o_err_count (o_err_count),
    .o_bit_count (o_bit_count)
  );

  task automatic tick(input logic en, input logic vld, input logic rb,
                      input logic xb, input logic rs);
    @(negedge clock);
    i_enable  = en;
    i_valid   = vld;
    i_ref_bit = rb;
    i_rx_bit  = xb;
    i_resync  = rs;
    @(posedge clock);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(1, 0));
  endfunction

  // rx is the reference delayed by 7 samples, optionally inverted.
  task automatic sample(input logic inv);
    logic b;
    b = lfsr[8];
    lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    hist = {hist[62:0], b};
    tick(1'b1, 1'b1, b, hist[7] ^ inv, 1'b0);
  endtask

  task automatic run_clean(input int n);
    for (int i = 0; i < n; i++) sample(1'b0);
  endtask

  task automatic lk_sample(input logic inv);
    sample(inv);
    since_lock++;
    exp_bits++;
    if (inv) exp_err++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    i_reset   = 1'b1;
    i_enable  = 1'b1;
    i_valid   = 1'b1;
    i_ref_bit = 1'b1;
    i_rx_bit  = 1'b0;
    i_resync  = 1'b0;
    @(posedge clock);
    #1;
    i_reset = 1'b0;
    i_valid = 1'b0;
    hist = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL %s locked: got %0b expected 0", tag, o_locked);
    end
    checks++;
    if (o_delay !== 5'd0) begin
      errors++;
      $display("FAIL %s delay: got %0d expected 0", tag, o_delay);
    end
    checks++;
    if (o_min_err !== 6'h3F) begin
      errors++;
      $display("FAIL %s min_err: got %0d expected 63", tag, o_min_err);
    end
    checks++;
    if (o_err_count !== 64'd0) begin
      errors++;
      $display("FAIL %s err_count: got %0d expected 0", tag, o_err_count);
    end
    checks++;
    if (o_bit_count !== 64'd0) begin
      errors++;
      $display("FAIL %s bit_count: got %0d expected 0", tag, o_bit_count);
    end
  endtask

  task automatic expect_lock_at_248(input string tag);
    run_clean(247);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL %s early_lock: got %0b expected 0", tag, o_locked);
    end
    sample(1'b0);
    checks++;
    if (o_locked !== 1'b1 || o_delay !== 5'd7) begin
      errors++;
      $display("FAIL %s lock: got locked=%0b delay=%0d expected 1/7",
               tag, o_locked, o_delay);
    end
    since_lock = 0;
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_outputs("reset");
  endtask

  task automatic test_lock_delay7();
    expect_lock_at_248("lock7");
    checks++;
    if (o_min_err !== 6'd0) begin
      errors++;
      $display("FAIL lock7 min_err: got %0d expected 0", o_min_err);
    end
    exp_bits = 0;
    exp_err = 0;
    for (int i = 0; i < 100; i++) lk_sample(1'b0);
    checks++;
    if (o_bit_count !== 64'd100 || o_err_count !== 64'd0) begin
      errors++;
      $display("FAIL lock7 counts: got bits=%0d errs=%0d expected 100/0",
               o_bit_count, o_err_count);
    end
  endtask

  task automatic test_isolated_errors();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 9; i++) lk_sample(1'b0);
      lk_sample(1'b1);
    end
    checks++;
    if (o_err_count !== 64'(exp_err) || exp_err != 3) begin
      errors++;
      $display("FAIL isolated err_count: got %0d expected 3", o_err_count);
    end
    checks++;
    if (o_bit_count !== 64'(exp_bits)) begin
      errors++;
      $display("FAIL isolated bit_count: got %0d expected %0d",
               o_bit_count, exp_bits);
    end
    checks++;
    if (o_locked !== 1'b1) begin
      errors++;
      $display("FAIL isolated locked: got %0b expected 1", o_locked);
    end
  endtask

  task automatic test_los_relock();
    while (since_lock % WINDOW != 0) lk_sample(1'b0);
    for (int i = 0; i < 10; i++) lk_sample(1'b1);
    for (int i = 0; i < 20; i++) lk_sample(1'b0);
    checks++;
    if (o_locked !== 1'b1) begin
      errors++;
      $display("FAIL los_midwin locked: got %0b expected 1", o_locked);
    end
    lk_sample(1'b0);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL los_drop locked: got %0b expected 0", o_locked);
    end
    checks++;
    if (o_err_count !== 64'(exp_err) || o_bit_count !== 64'(exp_bits)) begin
      errors++;
      $display("FAIL los_drop counts: got %0d/%0d expected %0d/%0d",
               o_err_count, o_bit_count, exp_err, exp_bits);
    end
    checks++;
    if (o_min_err !== 6'h3F) begin
      errors++;
      $display("FAIL los_drop min_err: got %0d expected 63", o_min_err);
    end
    expect_lock_at_248("relock");
    checks++;
    if (o_err_count !== 64'(exp_err) || o_bit_count !== 64'(exp_bits)) begin
      errors++;
      $display("FAIL relock counts: got %0d/%0d expected %0d/%0d",
               o_err_count, o_bit_count, exp_err, exp_bits);
    end
  endtask

  task automatic test_resync();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_lock_at_248("resync_a");
    exp_bits = 0;
    exp_err = 0;
    for (int i = 0; i < 500; i++) lk_sample(i == 100 || i == 300);
    checks++;
    if (o_bit_count !== 64'd500 || o_err_count !== 64'd2) begin
      errors++;
      $display("FAIL resync_pre counts: got %0d/%0d expected 500/2",
               o_bit_count, o_err_count);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (o_locked !== 1'b0 || o_bit_count !== 64'd0 ||
        o_err_count !== 64'd0) begin
      errors++;
      $display("FAIL resync_clear: got locked=%0b bits=%0d errs=%0d expected 0/0/0",
               o_locked, o_bit_count, o_err_count);
    end
    expect_lock_at_248("resync_b");
  endtask

  task automatic test_one_err_per_window();
    do_reset();
    for (int s = 0; s < 991; s++) sample(s % WINDOW == 0);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL sweep_early locked: got %0b expected 0", o_locked);
    end
    sample(1'b0);
    checks++;
    if (o_locked !== 1'b1 || o_delay !== 5'd7 || o_min_err !== 6'd1) begin
      errors++;
      $display("FAIL sweep_lock: got locked=%0b delay=%0d min=%0d expected 1/7/1",
               o_locked, o_delay, o_min_err);
    end
  endtask

  task automatic sparse_sample(input int n);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, rnd(), rnd(), 1'b0);
    if (n == 100)
      for (int k = 0; k < 20; k++) tick(1'b0, 1'b1, rnd(), rnd(), 1'b0);
    sample(1'b0);
  endtask

  task automatic test_sparse_valid();
    do_reset();
    for (int n = 0; n < 247; n++) sparse_sample(n);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL sparse_early locked: got %0b expected 0", o_locked);
    end
    sparse_sample(247);
    checks++;
    if (o_locked !== 1'b1 || o_delay !== 5'd7) begin
      errors++;
      $display("FAIL sparse_lock: got locked=%0b delay=%0d expected 1/7",
               o_locked, o_delay);
    end
    for (int n = 0; n < 100; n++) sparse_sample(n);
    checks++;
    if (o_bit_count !== 64'd100 || o_err_count !== 64'd0) begin
      errors++;
      $display("FAIL sparse_counts: got %0d/%0d expected 100/0",
               o_bit_count, o_err_count);
    end
  endtask

  task automatic test_reset_midway();
    do_reset();
    check_reset_outputs("reset_lock");
    run_clean(50);
    do_reset();
    check_reset_outputs("reset_search");
    expect_lock_at_248("reset_relock");
  endtask

  initial begin
    test_reset();
    test_lock_delay7();
    test_isolated_errors();
    test_los_relock();
    test_resync();
    test_one_err_per_window();
    test_sparse_valid();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prbs_ber_checker.md
Name: prbs_ber_checker

Overview:
- Downstream of the PRBS9 generator: takes the generator's reference bit (I branch) and the bit recovered after the TX filter / channel / slicer path.
- Sweeps candidate delays to find the path latency, then locks and counts bit errors and total compared bits.
- Sits at the end of the TX-filter test chain and feeds the results readout (VIO/registers).

Parameters:
- NB_DELAY, 9, width of delay index; search covers delays 0..2**NB_DELAY-1.
- WINDOW, 511, valid samples compared per candidate delay and per lock-monitor window.
- NB_WIN, 9, width of window counters; must satisfy 2**NB_WIN > WINDOW.
- LOS_THRESH, 64, error count in one locked window above which lock is dropped.
- NB_COUNT, 64, width of error and bit counters.

Ports:
- clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  global enable; low freezes all state
- i_valid  in  1  one-cycle strobe per symbol; qualifies i_ref_bit and i_rx_bit
- i_ref_bit  in  1  reference bit from the PRBS9 generator
- i_rx_bit  in  1  received/sliced bit
- i_resync  in  1  single-cycle pulse; restart search and clear counters
- o_locked  out  1  high while in LOCKED
- o_delay  out  NB_DELAY  locked delay (valid when o_locked)
- o_min_err  out  NB_WIN+1  best window error count found in the last search
- o_err_count  out  NB_COUNT  accumulated bit errors while locked
- o_bit_count  out  NB_COUNT  accumulated compared bits while locked

Behaviour:
- Sample = cycle with i_enable && i_valid. Nothing changes on non-sample cycles.
- Reference delay line: shift register of 2**NB_DELAY-1 bits, shifted on each sample. Tap(0) = current i_ref_bit; tap(d) = i_ref_bit from d samples earlier.
- mismatch = i_rx_bit XOR tap(cur_d), evaluated combinationally in the sample cycle. All state updates at that clock edge; outputs are registered with one-cycle latency.
- Reset values:
  - state=SEARCH, cur_d=0, win_cnt=0, err_win=0.
  - min_err = all ones (also drives o_min_err), best_d=0.
  - o_locked=0, o_delay=0, o_err_count=0, o_bit_count=0.
  - Delay line cleared to 0.
- Priority: i_reset > i_resync > sample.
- SEARCH, on each sample:
  - err_win += mismatch; win_cnt += 1.
  - On the sample where win_cnt == WINDOW-1, let final = err_win + mismatch:
    - if final < min_err: min_err <= final, best_d <= cur_d (strict compare, so the lowest delay wins ties).
    - if final == 0: go to LOCKED with o_delay <= cur_d immediately (early lock).
    - else if cur_d == max: go to LOCKED with o_delay <= best delay, including this window's update.
    - else: cur_d += 1.
    - In all cases clear err_win and win_cnt.
- Entering LOCKED: o_locked=1 from the next cycle. o_err_count and o_bit_count start from 0, or from their held values when LOCKED is re-entered after a loss of lock.
- LOCKED, on each sample:
  - o_bit_count += 1, o_err_count += mismatch; both saturate at all ones.
  - The lock monitor runs the same window logic. At the end of each window, if final > LOS_THRESH: go to SEARCH with o_locked=0, cur_d=0, min_err = all ones. Counters hold and are not cleared.
- i_resync: go to SEARCH, clear o_err_count, o_bit_count, window and search state. Delay line contents are kept.
- i_enable low mid-window: window resumes where it stopped; no sample is lost or double-counted.
- Reset mid-search or mid-lock: everything returns to reset values at the next edge.

Decomposition:
- Shared package: NB_DELAY, NB_WIN, NB_COUNT defaults; state encoding (SEARCH=1'b0, LOCKED=1'b1); PRBS9 seed constant 9'h0AB shared with the generator.
- Natural sub-module: ber_window_counter. It holds the win_cnt/err_win pair and asserts window_done with the final count. It is used once and shared between search and lock-monitor use.

Test Plan:
- Test parameters: NB_DELAY=5, WINDOW=31, NB_WIN=5, LOS_THRESH=4.
- rx = ref delayed 7 samples, continuous valid -> mismatches while cur_d<7; early lock on the first zero-error window at d=7, i.e. o_locked high the cycle after sample 8*31=248; o_delay=7, o_min_err=0. After 100 further samples: o_bit_count=100, o_err_count=0.
- After lock, invert rx on 3 isolated samples -> o_err_count=3, o_locked stays 1 (3 ≤ LOS_THRESH).
- After lock, invert 10 samples within one window -> o_err_count=10; o_locked drops after that window ends; re-lock at d=7 after a further 248 samples; o_err_count resumes from 10.
- rx = ref delayed 7 with 1 error per window (no zero window) -> full 32-delay sweep (992 samples), lock at o_delay=7, o_min_err=1.
- Valid every 4th cycle plus i_enable low for 20 cycles mid-window -> same lock delay and sample counts as the continuous case.
- i_resync pulse while locked with counts 500/2 -> next cycle o_locked=0 and counts=0, re-locks at d=7. i_reset asserted mid-search -> all outputs return to reset values.
